// File: rtl/program_loader.sv
// Purpose     : stream a program image into imem, pad the tail with FILL_WORD, then release the core.
// Latency     : an accepted word is written 1 cycle after its handshake; done rises 1 cycle after the final write.
// Backpressure: in_ready is high only while loading and out of reset; fill, done and error states refuse input.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-low reset
//   in_valid/in_ready      word-stream handshake; in_data is the word, in_last marks the final program word
//   imem_we/addr/wdata     registered imem write port, one strobe per written word
//   core_reset, done       core held in reset (active high) until the image is complete
//   err_overflow           MAX_WORDS words accepted with no in_last; sticky until reset
//   word_count             program words accepted, fill words excluded
//   csum                   present only when LOADER_CHECKSUM_EN is defined: wrapping sum of accepted words
module program_loader #(
    parameter int                  ADDR_W    = 8,
    parameter int                  DATA_W    = 32,
    parameter int                  BASE_ADDR = 0,
    parameter int                  MAX_WORDS = 256,
    parameter logic [DATA_W-1:0]   FILL_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FILL  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + MAX_WORDS - 1);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W + 1)'(MAX_WORDS - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                core_reset_q;
    logic                done_q;
    logic                err_q;
    logic [ADDR_W:0]     word_count_q;
    logic [ADDR_W-1:0]   fill_addr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q;
`endif

    // Fill continues from the last program word's address, so it never leaves a hole.
    assign fill_addr_d = addr_q + ADDR_ONE;

    // Gated by reset so the host never sees a handshake while the loader is being cleared.
    assign in_ready = (state_q == S_LOAD) && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            we_q         <= 1'b0;
            addr_q       <= BASE;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    we_q <= 1'b0;
                    if (in_valid) begin
                        // word_count is still below MAX_WORDS here, so its low bits are the index.
                        we_q         <= 1'b1;
                        addr_q       <= BASE + word_count_q[ADDR_W-1:0];
                        wdata_q      <= in_data;
                        word_count_q <= word_count_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                        csum_q       <= csum_q + in_data;
`endif
                        // A last word landing on the final slot is an exact fit, not an overflow.
                        if (word_count_q == LAST_IDX) begin
                            state_q <= in_last ? S_DONE : S_ERROR;
                        end else if (in_last) begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    we_q    <= 1'b1;
                    addr_q  <= fill_addr_d;
                    wdata_q <= FILL_WORD;
                    if (fill_addr_d == LAST_ADDR) begin
                        state_q <= S_DONE;
                    end
                end
                // Terminal states drop the strobe on their first edge, i.e. the edge after the final write.
                S_DONE: begin
                    we_q         <= 1'b0;
                    done_q       <= 1'b1;
                    core_reset_q <= 1'b0;
                end
                S_ERROR: begin
                    we_q  <= 1'b0;
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign err_overflow = err_q;
    assign word_count   = word_count_q;
`ifdef LOADER_CHECKSUM_EN
    assign csum         = csum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 32;
    localparam int          MAXW   = 8;
    localparam logic [31:0] FILL   = 32'h00000013;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_reset;
    logic              done;
    logic              err_overflow;
    logic [ADDR_W:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    program_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0), .MAX_WORDS(MAXW), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .done(done), .err_overflow(err_overflow),
        .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("rst_in_ready_low", in_ready, 0);
        for (int i = 0; i < cycles; i++) tick();
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_in_ready", in_ready, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_csum", csum, 0);
`endif
        reset = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1);
    endtask

    // Reference model at transaction level: the image must be the accepted words in order followed
    // by FILL up to MAXW entries; each program word is written the cycle after its handshake, fill
    // writes follow back-to-back, and done/err rises the cycle after the final write.
    task automatic run_stream(input logic [31:0] words[$], input bit has_last, input int gap_mode,
                              input int abort_addr, output bit aborted);
        int          limit;
        int          acc;
        int          gap;
        int          idle;
        int          done_cyc;
        int          err_cyc;
        int          acc_cyc[$];
        int          wa[$];
        int          wc[$];
        logic [31:0] wd[$];
        logic [31:0] sum;
        limit    = has_last ? words.size() : MAXW;
        acc      = 0;
        gap      = 0;
        idle     = 0;
        done_cyc = -1;
        err_cyc  = -1;
        sum      = '0;
        aborted  = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (imem_we) begin
                wa.push_back(int'(imem_addr));
                wd.push_back(imem_wdata);
                wc.push_back(cyc);
                if (int'(imem_addr) == abort_addr) begin
                    aborted  = 1'b1;
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    return;
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (err_overflow && err_cyc < 0) err_cyc = cyc;
            if (done_cyc >= 0 || err_cyc >= 0) idle++;
            if (idle > 3) break;
            chk("in_ready", in_ready, (acc < limit) ? 1 : 0);
            if (acc < words.size() && gap == 0) begin
                in_valid = 1'b1;
                in_data  = words[acc];
                in_last  = has_last && (acc == words.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                if (gap > 0) gap--;
            end
            if (in_valid && acc < limit) begin
                acc_cyc.push_back(cyc);
                sum = sum + in_data;
                acc++;
                gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? $urandom_range(0, 3) : 0;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("stream_finished", (done_cyc >= 0 || err_cyc >= 0) ? 1 : 0, 1);
        chk("n_writes", wa.size(), MAXW);
        for (int j = 0; j < wa.size(); j++) begin
            chk("wr_addr", wa[j], j);
            chk("wr_data", wd[j], (j < acc) ? words[j] : FILL);
            if (j < acc) chk("wr_cycle_prog", wc[j], acc_cyc[j] + 1);
            else if (j > 0) chk("wr_cycle_fill", wc[j], wc[j-1] + 1);
        end
        chk("word_count", word_count, acc);
        chk("final_in_ready", in_ready, 0);
        chk("final_we", imem_we, 0);
        if (has_last) begin
            if (wa.size() > 0) chk("done_cycle", done_cyc, wc[wa.size()-1] + 1);
            chk("done", done, 1);
            chk("core_reset", core_reset, 0);
            chk("err", err_overflow, 0);
        end else begin
            if (wa.size() > 0) chk("err_cycle", err_cyc, wc[wa.size()-1] + 1);
            chk("err", err_overflow, 1);
            chk("done", done, 0);
            chk("core_reset", core_reset, 1);
        end
`ifdef LOADER_CHECKSUM_EN
        chk("csum", csum, sum);
`endif
    endtask

    initial begin
        logic [31:0] q[$];
        bit          ab;
        int          n;
        bit          lst;

        // Test 1: three words back-to-back, fill 3..7.
        do_reset(2);
        q = '{32'hA, 32'hB, 32'hC};
        run_stream(q, 1'b1, 0, -1, ab);

        // Test 2: same stream with 2-cycle gaps.
        do_reset(1);
        run_stream(q, 1'b1, 1, -1, ab);

        // Test 3: eight words without last, plus a ninth that must be refused.
        do_reset(1);
        q = {};
        for (int i = 0; i < MAXW + 1; i++) q.push_back($urandom);
        run_stream(q, 1'b0, 0, -1, ab);

        // Test 4: exact fit, last on the eighth word.
        do_reset(1);
        q = {};
        for (int i = 0; i < MAXW; i++) q.push_back($urandom);
        run_stream(q, 1'b1, 2, -1, ab);

        // Test 5: reset pulse while fill is writing address 5, then reload from address 0.
        do_reset(1);
        q = '{32'hA, 32'hB, 32'hC};
        run_stream(q, 1'b1, 0, 5, ab);
        chk("abort_reached_addr5", ab, 1);
        do_reset(1);
        q = {};
        for (int i = 0; i < 4; i++) q.push_back($urandom);
        run_stream(q, 1'b1, 0, -1, ab);

        // Random streams: random length, last or overflow, random gaps.
        for (int r = 0; r < 12; r++) begin
            do_reset(1 + (r % 2));
            lst = ($urandom_range(0, 3) != 0);
            n   = lst ? $urandom_range(1, MAXW) : MAXW + 1;
            q   = {};
            for (int i = 0; i < n; i++) q.push_back($urandom);
            run_stream(q, lst, $urandom_range(0, 2), -1, ab);
        end

`ifdef LOADER_CHECKSUM_EN
        do_reset(1);
        q = '{32'd1, 32'd2, 32'd3};
        run_stream(q, 1'b1, 0, -1, ab);
        chk("csum_directed_6", csum, 32'd6);
        do_reset(1);
        q = '{32'hFFFFFFFF, 32'd2};
        run_stream(q, 1'b1, 0, -1, ab);
        chk("csum_wrap_1", csum, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
